sram_port_arbiter: RTL and testbench

Two-requester arbiter sharing the single-port 128-bit tiny-SoC SRAM between the AXI slave memory side (port 0) and a debug/preload requester (port 1). It grants one request per cycle using round-robin with optional burst lock. It drives the SRAM request bus and returns read data to the owning port after a fixed, tagged read latency. It sits between `our_axi_slave128`'s memory interface and the SRAM macro.

---
 rtl/sram_port_arbiter.sv | 103 ++++++++++
 tb/tb_sram_port_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin/lock arbiter sharing one SRAM between two ports, with tagged read return.
// Optional performance counters are built only when SRAM_ARB_PERF_CNT_EN is defined.
module sram_port_arbiter #(
  parameter int SRAM_ADDR_WIDTH = 21,
  parameter int SRAM_DATA_WIDTH = 128,
  parameter int READ_LATENCY    = 1
) (
  input  logic                       pll_core_cpuclk,
  input  logic                       sys_rst,
  input  logic                       m0_req_i,
  input  logic                       m0_lock_i,
  input  logic                       m0_we_i,
  input  logic [SRAM_ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [SRAM_DATA_WIDTH-1:0] m0_wdata_i,
  input  logic [SRAM_DATA_WIDTH-1:0] m0_strb_i,
  output logic                       m0_gnt_o,
  output logic                       m0_rvalid_o,
  output logic [SRAM_DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                       m1_req_i,
  input  logic                       m1_lock_i,
  input  logic                       m1_we_i,
  input  logic [SRAM_ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [SRAM_DATA_WIDTH-1:0] m1_wdata_i,
  input  logic [SRAM_DATA_WIDTH-1:0] m1_strb_i,
  output logic                       m1_gnt_o,
  output logic                       m1_rvalid_o,
  output logic [SRAM_DATA_WIDTH-1:0] m1_rdata_o,
  output logic                       mem_req_o,
  output logic                       mem_we_o,
  output logic [SRAM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [SRAM_DATA_WIDTH-1:0] mem_wdata_o,
  output logic [SRAM_DATA_WIDTH-1:0] mem_strb_o,
  input  logic [SRAM_DATA_WIDTH-1:0] mem_rdata_i,
  output logic [31:0]                perf_gnt0_o,
  output logic [31:0]                perf_gnt1_o,
  output logic [31:0]                perf_conflict_o
);
  typedef enum logic [1:0] {NONE = 2'd0, P0 = 2'd1, P1 = 2'd2} lock_t;
  lock_t lock_q, lock_d;
  logic rr_q, rr_d;
  logic gnt0, gnt1, rd;
  logic [READ_LATENCY-1:0] tv_q, tp_q;
  assign gnt0 = !sys_rst && m0_req_i && (lock_q == P0 || (lock_q == NONE && (!m1_req_i || !rr_q)));
  assign gnt1 = !sys_rst && m1_req_i && (lock_q == P1 || (lock_q == NONE && (!m0_req_i || rr_q)));
  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;
  always_comb begin
    rr_d   = gnt0 ? 1'b1 : gnt1 ? 1'b0 : rr_q;
    lock_d = lock_q;
    lock_d = gnt0 ? (m0_lock_i ? P0 : NONE) :
             gnt1 ? (m1_lock_i ? P1 : NONE) :
             ((lock_q == P0 && !m0_lock_i) || (lock_q == P1 && !m1_lock_i)) ? NONE : lock_q;
  end
  assign mem_req_o   = gnt0 | gnt1;
  assign mem_we_o    = gnt0 ? m0_we_i    : gnt1 ? m1_we_i    : 1'b0;
  assign mem_addr_o  = gnt0 ? m0_addr_i  : gnt1 ? m1_addr_i  : '0;
  assign mem_wdata_o = gnt0 ? m0_wdata_i : gnt1 ? m1_wdata_i : '0;
  assign mem_strb_o  = gnt0 ? m0_strb_i  : gnt1 ? m1_strb_i  : '0;
  assign rd = mem_req_o && !mem_we_o;
  always_ff @(posedge pll_core_cpuclk) begin
    if (sys_rst) begin
      rr_q   <= 1'b0;
      lock_q <= NONE;
      tv_q   <= '0;
      tp_q   <= '0;
    end else begin
      rr_q    <= rr_d;
      lock_q  <= lock_d;
      tv_q[0] <= rd;
      tp_q[0] <= gnt1;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tv_q[i] <= tv_q[i-1];
        tp_q[i] <= tp_q[i-1];
      end
    end
  end
  // a tag emerging during reset belongs to a flushed read, so it is masked
  assign m0_rvalid_o = !sys_rst && tv_q[READ_LATENCY-1] && !tp_q[READ_LATENCY-1];
  assign m1_rvalid_o = !sys_rst && tv_q[READ_LATENCY-1] && tp_q[READ_LATENCY-1];
  assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;
`ifdef SRAM_ARB_PERF_CNT_EN
  logic [31:0] pg0_q, pg1_q, pc_q;
  always_ff @(posedge pll_core_cpuclk) begin
    if (sys_rst) begin
      pg0_q <= '0;
      pg1_q <= '0;
      pc_q  <= '0;
    end else begin
      pg0_q <= pg0_q + 32'(gnt0);
      pg1_q <= pg1_q + 32'(gnt1);
      pc_q  <= pc_q + 32'((m0_req_i && !gnt0) || (m1_req_i && !gnt1));
    end
  end
  assign perf_gnt0_o     = pg0_q;
  assign perf_gnt1_o     = pg1_q;
  assign perf_conflict_o = pc_q;
`else
  assign perf_gnt0_o     = '0;
  assign perf_gnt1_o     = '0;
  assign perf_conflict_o = '0;
`endif
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: randomized + directed scoreboard bench for sram_port_arbiter.
module tb_sram_port_arbiter;
  localparam int RL = 2;
`ifdef SRAM_ARB_PERF_CNT_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  typedef struct packed {
    logic         req;
    logic         lock;
    logic         we;
    logic [20:0]  addr;
    logic [127:0] wdata;
    logic [127:0] strb;
  } txn_t;
  typedef struct packed {
    logic         p;
    logic [127:0] d;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic sys_rst = 1'b1;
  logic req [2], lock [2], we [2];
  logic [20:0] addr [2];
  logic [127:0] wdata [2], strb [2];
  logic m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [127:0] m0_rdata_o, m1_rdata_o;
  logic mem_req_o, mem_we_o;
  logic [20:0] mem_addr_o;
  logic [127:0] mem_wdata_o, mem_strb_o, mem_rdata_i;
  logic [31:0] perf_gnt0_o, perf_gnt1_o, perf_conflict_o;

  sram_port_arbiter #(.SRAM_ADDR_WIDTH(21), .SRAM_DATA_WIDTH(128), .READ_LATENCY(RL)) dut (
    .pll_core_cpuclk(clk), .sys_rst(sys_rst),
    .m0_req_i(req[0]), .m0_lock_i(lock[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]),
    .m0_wdata_i(wdata[0]), .m0_strb_i(strb[0]), .m0_gnt_o(m0_gnt_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(req[1]), .m1_lock_i(lock[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]),
    .m1_wdata_i(wdata[1]), .m1_strb_i(strb[1]), .m1_gnt_o(m1_gnt_o),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o), .mem_rdata_i(mem_rdata_i),
    .perf_gnt0_o(perf_gnt0_o), .perf_gnt1_o(perf_gnt1_o), .perf_conflict_o(perf_conflict_o)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  bit mon_en = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  function automatic logic [127:0] init_val(input int i);
    return (i == 'h10) ? {16{8'hA5}} : {4{32'(i) * 32'h9E3779B1}};
  endfunction

  // SRAM stand-in: driven only by the DUT's mem_* bus, junk on rdata when idle
  logic [127:0] sram [512];
  logic [127:0] rpipe [RL];
  bit mem_ok = 1'b0;
  always @(posedge clk) begin
    if (!mem_ok) begin
      for (int i = 0; i < 512; i++) sram[i] <= init_val(i);
      mem_ok <= 1'b1;
    end else if (mem_req_o && mem_we_o)
      sram[mem_addr_o[8:0]] <= (sram[mem_addr_o[8:0]] & ~mem_strb_o) | (mem_wdata_o & mem_strb_o);
    rpipe[0] <= (mem_req_o && !mem_we_o) ? sram[mem_addr_o[8:0]] : {$urandom, $urandom, $urandom, $urandom};
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata_i = rpipe[RL-1];

  // reference model state
  logic [127:0] mm [512];
  txn_t pq [2][$];
  exp_t exp_q [$];
  txn_t cur [2];
  int own = -1, pref = 0;
  int unsigned pg0 = 0, pg1 = 0, pc = 0;
  bit rst_req = 1'b0;

  exp_t me;
  always @(negedge clk) if (mon_en) begin
    if (m0_rvalid_o || m1_rvalid_o) begin
      if (exp_q.size() == 0) chk("rv_unexpected", 128'({m1_rvalid_o, m0_rvalid_o}), 128'(0));
      else begin
        me = exp_q.pop_front();
        chk("rv_port", 128'({m1_rvalid_o, m0_rvalid_o}), me.p ? 128'(2) : 128'(1));
        chk("rv_data", me.p ? m1_rdata_o : m0_rdata_o, me.d);
        chk("rv_cycle", 128'(cyc), 128'(me.due));
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      me = exp_q.pop_front();
      chk("rv_missing", 128'({m1_rvalid_o, m0_rvalid_o}), me.p ? 128'(2) : 128'(1));
    end
    if (!m0_rvalid_o) chk("rd0_idle", m0_rdata_o, '0);
    if (!m1_rvalid_o) chk("rd1_idle", m1_rdata_o, '0);
  end

  function automatic txn_t mk(input bit r, input bit l, input bit w, input int a);
    txn_t t;
    t.req = r; t.lock = l; t.we = w; t.addr = 21'(a);
    t.wdata = {$urandom, $urandom, $urandom, $urandom};
    t.strb  = {$urandom, $urandom, $urandom, $urandom};
    return t;
  endfunction

  task automatic cycle();
    int g;
    txn_t gt;
    @(posedge clk);
    #1;
    sys_rst = rst_req;
    if (rst_req) exp_q.delete();
    for (int p = 0; p < 2; p++) begin
      cur[p] = pq[p].size() != 0 ? pq[p][0] : mk(1'b0, 1'b0, $urandom_range(1), $urandom);
      req[p] = cur[p].req; lock[p] = cur[p].lock; we[p] = cur[p].we;
      addr[p] = cur[p].addr; wdata[p] = cur[p].wdata; strb[p] = cur[p].strb;
    end
    @(negedge clk);
    chk("perf_gnt0", 128'(perf_gnt0_o), PEN ? 128'(pg0) : 128'(0));
    chk("perf_gnt1", 128'(perf_gnt1_o), PEN ? 128'(pg1) : 128'(0));
    chk("perf_conflict", 128'(perf_conflict_o), PEN ? 128'(pc) : 128'(0));
    if (rst_req) g = -1;
    else if (own >= 0) g = cur[own].req ? own : -1;
    else if (cur[0].req && cur[1].req) g = pref;
    else g = cur[0].req ? 0 : cur[1].req ? 1 : -1;
    gt = g < 0 ? '0 : cur[g == 1];
    chk("gnt", 128'({m1_gnt_o, m0_gnt_o}), g < 0 ? 128'(0) : g == 0 ? 128'(1) : 128'(2));
    chk("mem_ctl", 128'({mem_req_o, mem_we_o, mem_addr_o}), 128'({g >= 0, gt.we, gt.addr}));
    chk("mem_wdata", mem_wdata_o, gt.wdata);
    chk("mem_strb", mem_strb_o, gt.strb);
    if (g == 0) pg0++;
    if (g == 1) pg1++;
    if ((cur[0].req && g != 0) || (cur[1].req && g != 1)) pc++;
    if (g >= 0) begin
      pref = 1 - g;
      own = gt.lock ? g : -1;
      if (gt.we) mm[gt.addr[8:0]] = (mm[gt.addr[8:0]] & ~gt.strb) | (gt.wdata & gt.strb);
      else exp_q.push_back('{p: g == 1, d: mm[gt.addr[8:0]], due: cyc + RL});
      void'(pq[g].pop_front());
    end else if (own >= 0 && !cur[own].lock) own = -1;
    for (int p = 0; p < 2; p++)
      if (pq[p].size() != 0 && !pq[p][0].req) void'(pq[p].pop_front());
    if (rst_req) begin
      own = -1; pref = 0; pg0 = 0; pg1 = 0; pc = 0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((pq[0].size() != 0 || pq[1].size() != 0) && n < 5000) begin
      cycle();
      n++;
    end
    chk("drain_timeout", 128'(pq[0].size() + pq[1].size()), 128'(0));
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mm[i] = init_val(i);
    for (int p = 0; p < 2; p++) begin
      req[p] = 0; lock[p] = 0; we[p] = 0; addr[p] = '0; wdata[p] = '0; strb[p] = '0;
    end
    repeat (2) @(posedge clk);
    mon_en = 1'b1;
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    // single read from port 0 of the all-A5 word
    pq[0].push_back(mk(1, 0, 0, 'h10));
    drain();
    repeat (RL + 1) cycle();
    // both ports writing back-to-back
    for (int i = 0; i < 4; i++) begin
      pq[0].push_back(mk(1, 0, 1, 'h20 + i));
      pq[1].push_back(mk(1, 0, 1, 'h30 + i));
    end
    drain();
    // port 0 alone so port 1 is preferred, then a locked 4-beat port-1 burst
    pq[0].push_back(mk(1, 0, 1, 'h40));
    drain();
    for (int i = 0; i < 4; i++) pq[1].push_back(mk(1, i < 3, 1, 'h100 + i));
    for (int i = 0; i < 3; i++) pq[0].push_back(mk(1, 0, 0, 'h100 + i));
    drain();
    // interleaved reads and a write
    pq[0].push_back(mk(1, 0, 0, 'h20));
    pq[1].push_back(mk(1, 0, 0, 'h101));
    pq[0].push_back(mk(1, 0, 1, 'h21));
    pq[1].push_back(mk(1, 0, 0, 'h21));
    drain();
    repeat (RL + 1) cycle();
    // reset with two reads in flight
    pq[0].push_back(mk(1, 0, 0, 'h30));
    pq[1].push_back(mk(1, 0, 0, 'h31));
    repeat (2) cycle();
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    pq[0].push_back(mk(1, 0, 1, 'h50));
    pq[1].push_back(mk(1, 0, 1, 'h51));
    drain();
    // random traffic with idles and locks
    for (int i = 0; i < 200; i++)
      for (int p = 0; p < 2; p++) begin
        bit r;
        r = $urandom_range(3) != 0;
        pq[p].push_back(mk(r, r && $urandom_range(4) == 0, $urandom_range(1), $urandom_range(511)));
      end
    drain();
    repeat (RL + 2) cycle();
    chk("sb_empty", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
